// File: rtl/fp_pkg.sv
// Shared floating-point width constants and lane slicing helpers.
package fp_pkg;

    // Standard IEEE / ML format field widths
    localparam int FP32_SIG_WIDTH = 23;
    localparam int FP32_EXP_WIDTH = 8;
    localparam int FP16_SIG_WIDTH = 10;
    localparam int FP16_EXP_WIDTH = 5;
    localparam int BF16_SIG_WIDTH = 7;
    localparam int BF16_EXP_WIDTH = 8;

    // An aligned significand carries a hidden one, a carry and a sign bit
    // on top of the stored fraction.
    localparam int SIG_GUARD_BITS = 3;

    // Width of the two's-complement significand sum.
    function automatic int fp_sum_w(input int sig_width);
        return sig_width + SIG_GUARD_BITS;
    endfunction

    // Width of a leading-zero count able to hold 0..w.
    function automatic int fp_lzc_w(input int w);
        return $clog2(w + 1);
    endfunction

    // Low bit of lane `lane` in a flat vector of w-bit lanes.
    function automatic int fp_lane_lo(input int lane, input int w);
        return lane * w;
    endfunction

endpackage

// File: rtl/fp_sig_add_lane.sv
// One lane of significand add: sum, sign/magnitude split, zero flag and
// leading-zero count. Purely combinational; a disabled lane reports a clean
// zero with a zeroed exponent.
module fp_sig_add_lane import fp_pkg::*; #(
    parameter  int SIG_WIDTH = FP32_SIG_WIDTH,
    parameter  int EXP_WIDTH = FP32_EXP_WIDTH,
    localparam int W         = fp_sum_w(SIG_WIDTH),
    localparam int L         = fp_lzc_w(W)
) (
    input  logic                 en,
    input  logic [W-1:0]         sig1,
    input  logic [W-1:0]         sig2,
    input  logic [EXP_WIDTH-1:0] exp_in,
    output logic [W-1:0]         mag,
    output logic                 sign,
    output logic                 zero,
    output logic [L-1:0]         lzc,
    output logic [EXP_WIDTH-1:0] exp_out
);

    logic [W-1:0] sum;
    logic [W-1:0] neg;
    logic [W-1:0] mag_raw;
    logic [L-1:0] lzc_raw;
    logic         is_neg;

    // Carry out of the top bit is dropped; the most negative sum negates to
    // itself, which reads back correctly as an unsigned 2^(W-1) magnitude.
    assign sum     = sig1 + sig2;
    assign neg     = ~sum + 1'b1;
    assign is_neg  = sum[W-1];
    assign mag_raw = is_neg ? neg : sum;

    // Leading-zero count: ascending scan so the highest set bit wins last.
    always_comb begin
        lzc_raw = L'(W);
        for (int i = 0; i < W; i++) begin
            if (mag_raw[i]) lzc_raw = L'(W - 1 - i);
        end
    end

    // Lane enable gating of every result field.
    always_comb begin
        mag     = '0;
        sign    = 1'b0;
        zero    = 1'b1;
        lzc     = L'(W);
        exp_out = '0;
        if (en) begin
            mag     = mag_raw;
            sign    = is_neg;
            zero    = (mag_raw == '0);
            lzc     = lzc_raw;
            exp_out = exp_in;
        end
    end

endmodule

// File: rtl/fp_sig_add_pipe.sv
// Vector significand adder: LANES independent add/normalize-prep lanes
// followed by PIPE_DEPTH elastic register stages. All arithmetic sits ahead
// of the first stage; later stages only add delay for retiming. A single
// valid/advance chain drives the holds of every lane.
module fp_sig_add_pipe import fp_pkg::*; #(
    parameter  int SIG_WIDTH  = FP32_SIG_WIDTH,
    parameter  int EXP_WIDTH  = FP32_EXP_WIDTH,
    parameter  int LANES      = 16,
    parameter  int PIPE_DEPTH = 1,
    localparam int W          = fp_sum_w(SIG_WIDTH),
    localparam int L          = fp_lzc_w(W)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES-1:0]           in_lane_en,
    input  logic [LANES*W-1:0]         in_sig1,
    input  logic [LANES*W-1:0]         in_sig2,
    input  logic [LANES*EXP_WIDTH-1:0] in_exponent,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*W-1:0]         out_sig,
    output logic [LANES-1:0]           out_sign,
    output logic [LANES-1:0]           out_zero,
    output logic [LANES*L-1:0]         out_lzc,
    output logic [LANES*EXP_WIDTH-1:0] out_exponent
);

    // Per-lane record carried down the pipe: {exponent, lzc, zero, sign, mag}
    localparam int LW = W + 2 + L + EXP_WIDTH;

    if (PIPE_DEPTH < 1 || PIPE_DEPTH > 3) begin : g_bad_depth
        $error("fp_sig_add_pipe: PIPE_DEPTH must be 1..3");
    end

    logic [LANES-1:0][W-1:0]         c_mag;
    logic [LANES-1:0]                c_sign;
    logic [LANES-1:0]                c_zero;
    logic [LANES-1:0][L-1:0]         c_lzc;
    logic [LANES-1:0][EXP_WIDTH-1:0] c_exp;
    logic [LANES-1:0][LW-1:0]        comb_rec;

    // Stage registers; index k holds the output of stage k+1.
    logic [PIPE_DEPTH-1:0]                  vld_q;
    logic [PIPE_DEPTH-1:0][LANES-1:0][LW-1:0] rec_q;

    // Input side at index 0, stage k output at index k.
    logic [PIPE_DEPTH:0]                    vld_pipe;
    logic [PIPE_DEPTH:0][LANES-1:0][LW-1:0] rec_pipe;

    // go[k]: stage k+1 loads this cycle.
    logic [PIPE_DEPTH-1:0]                  go;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        fp_sig_add_lane #(
            .SIG_WIDTH (SIG_WIDTH),
            .EXP_WIDTH (EXP_WIDTH)
        ) u_lane (
            .en      (in_lane_en[i]),
            .sig1    (in_sig1[fp_lane_lo(i, W) +: W]),
            .sig2    (in_sig2[fp_lane_lo(i, W) +: W]),
            .exp_in  (in_exponent[fp_lane_lo(i, EXP_WIDTH) +: EXP_WIDTH]),
            .mag     (c_mag[i]),
            .sign    (c_sign[i]),
            .zero    (c_zero[i]),
            .lzc     (c_lzc[i]),
            .exp_out (c_exp[i])
        );

        assign comb_rec[i] = {c_exp[i], c_lzc[i], c_zero[i], c_sign[i], c_mag[i]};

        assign {out_exponent[fp_lane_lo(i, EXP_WIDTH) +: EXP_WIDTH],
                out_lzc[fp_lane_lo(i, L) +: L],
                out_zero[i],
                out_sign[i],
                out_sig[fp_lane_lo(i, W) +: W]} = rec_pipe[PIPE_DEPTH][i];
    end

    assign vld_pipe = {vld_q, in_valid};
    assign rec_pipe = {rec_q, comb_rec};

    // Advance chain from the output back: a stage loads when it is empty or
    // its successor is taking its beat this cycle.
    always_comb begin
        logic chain;
        chain = out_ready;
        go    = '0;
        for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
            chain = !vld_q[k] || chain;
            go[k] = chain;
        end
    end

    assign in_ready  = go[0];
    assign out_valid = vld_pipe[PIPE_DEPTH];

    // Stage registers: shift on advance, hold otherwise; data only captured
    // from a valid predecessor so a bubble never disturbs held output data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            rec_q <= '0;
        end else begin
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                if (go[k]) begin
                    vld_q[k] <= vld_pipe[k];
                    if (vld_pipe[k]) rec_q[k] <= rec_pipe[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_sig_add_pipe.sv
// Bench for fp_sig_add_pipe: a depth-2 and a depth-3 instance share the
// input stream; each has its own reset and out_ready.
module tb_fp_sig_add_pipe;

    localparam int SW = 23;
    localparam int E  = 8;
    localparam int N  = 4;
    localparam int W  = SW + 3;
    localparam int L  = $clog2(W + 1);

    typedef struct packed {
        logic [N*W-1:0] sig;
        logic [N-1:0]   sign;
        logic [N-1:0]   zero;
        logic [N*L-1:0] lzc;
        logic [N*E-1:0] ex;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst2, rst3, in_valid, ordy2, ordy3;
    logic [N-1:0]   lane_en;
    logic [N*W-1:0] sig1, sig2;
    logic [N*E-1:0] expo;

    logic           irdy2, ovld2, irdy3, ovld3;
    logic [N*W-1:0] osig2, osig3;
    logic [N-1:0]   osign2, osign3, ozero2, ozero3;
    logic [N*L-1:0] olzc2, olzc3;
    logic [N*E-1:0] oexp2, oexp3;

    beat_t exp2_q[$], got2_q[$], exp3_q[$], got3_q[$];
    beat_t prev2, prev3;
    logic  hold2 = 1'b0, hold3 = 1'b0;
    int    hold_err2 = 0, hold_err3 = 0;
    int    total = 0, bad = 0;

    fp_sig_add_pipe #(.SIG_WIDTH(SW), .EXP_WIDTH(E), .LANES(N), .PIPE_DEPTH(2)) u_d2 (
        .clk(clk), .reset_n(rst2), .in_valid(in_valid), .in_ready(irdy2),
        .in_lane_en(lane_en), .in_sig1(sig1), .in_sig2(sig2), .in_exponent(expo),
        .out_valid(ovld2), .out_ready(ordy2), .out_sig(osig2), .out_sign(osign2),
        .out_zero(ozero2), .out_lzc(olzc2), .out_exponent(oexp2));

    fp_sig_add_pipe #(.SIG_WIDTH(SW), .EXP_WIDTH(E), .LANES(N), .PIPE_DEPTH(3)) u_d3 (
        .clk(clk), .reset_n(rst3), .in_valid(in_valid), .in_ready(irdy3),
        .in_lane_en(lane_en), .in_sig1(sig1), .in_sig2(sig2), .in_exponent(expo),
        .out_valid(ovld3), .out_ready(ordy3), .out_sig(osig3), .out_sign(osign3),
        .out_zero(ozero3), .out_lzc(olzc3), .out_exponent(oexp3));

    // Reference: true signed sum wrapped to W bits, then |sum| and its bit length.
    function automatic beat_t model(input logic [N-1:0] en, input logic [N*W-1:0] a,
                                    input logic [N*W-1:0] b, input logic [N*E-1:0] x);
        beat_t  r;
        longint half, full, sa, sb, s, m, t;
        int     bl;
        half = longint'(1) << (W - 1);
        full = half * 2;
        r = '0;
        for (int i = 0; i < N; i++) begin
            sa = longint'(a[i*W +: W]);
            sb = longint'(b[i*W +: W]);
            if (sa >= half) sa = sa - full;
            if (sb >= half) sb = sb - full;
            s = sa + sb;
            if (s >= half) s = s - full;
            else if (s < -half) s = s + full;
            m = (s < 0) ? -s : s;
            bl = 0;
            t = m;
            while (t > 0) begin t = t / 2; bl++; end
            if (en[i]) begin
                r.sig[i*W +: W] = m[W-1:0];
                r.sign[i]       = (s < 0);
                r.zero[i]       = (m == 0);
                r.lzc[i*L +: L] = L'(W - bl);
                r.ex[i*E +: E]  = x[i*E +: E];
            end else begin
                r.zero[i]       = 1'b1;
                r.lzc[i*L +: L] = L'(W);
            end
        end
        return r;
    endfunction

    function automatic beat_t cap(input logic [N*W-1:0] s, input logic [N-1:0] sg,
                                  input logic [N-1:0] z, input logic [N*L-1:0] lz,
                                  input logic [N*E-1:0] x);
        beat_t r;
        r.sig = s; r.sign = sg; r.zero = z; r.lzc = lz; r.ex = x;
        return r;
    endfunction

    // Handshake monitors: the negedge view is what the next rising edge samples.
    always @(negedge clk) begin
        if (rst2 !== 1'b1) hold2 = 1'b0;
        else begin
            if (in_valid && irdy2) exp2_q.push_back(model(lane_en, sig1, sig2, expo));
            if (hold2 && (ovld2 !== 1'b1 || cap(osig2, osign2, ozero2, olzc2, oexp2) !== prev2))
                hold_err2++;
            if (ovld2 && ordy2) got2_q.push_back(cap(osig2, osign2, ozero2, olzc2, oexp2));
            hold2 = ovld2 && (ordy2 === 1'b0);
            prev2 = cap(osig2, osign2, ozero2, olzc2, oexp2);
        end
    end

    always @(negedge clk) begin
        if (rst3 !== 1'b1) hold3 = 1'b0;
        else begin
            if (in_valid && irdy3) exp3_q.push_back(model(lane_en, sig1, sig2, expo));
            if (hold3 && (ovld3 !== 1'b1 || cap(osig3, osign3, ozero3, olzc3, oexp3) !== prev3))
                hold_err3++;
            if (ovld3 && ordy3) got3_q.push_back(cap(osig3, osign3, ozero3, olzc3, oexp3));
            hold3 = ovld3 && (ordy3 === 1'b0);
            prev3 = cap(osig3, osign3, ozero3, olzc3, oexp3);
        end
    end

    task automatic drive_rand();
        logic [W-1:0] a, b;
        lane_en = ($urandom_range(0, 7) == 0) ? N'($urandom) : '1;
        for (int i = 0; i < N; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            case ($urandom_range(0, 5))
                0: b = ~a + 1'b1;
                1: begin a = W'(1) << (W - 1); b = '0; end
                2: begin a = W'($urandom_range(0, 15)); b = ~W'($urandom_range(0, 15)) + 1'b1; end
                default: ;
            endcase
            sig1[i*W +: W] = a;
            sig2[i*W +: W] = b;
            expo[i*E +: E] = E'($urandom);
        end
    endtask

    task automatic clear_queues();
        exp2_q.delete(); got2_q.delete(); exp3_q.delete(); got3_q.delete();
    endtask

    task automatic drain();
        @(posedge clk); #1;
        in_valid = 1'b0; ordy2 = 1'b1; ordy3 = 1'b1;
        for (int c = 0; c < 60 && (got2_q.size() < exp2_q.size() || got3_q.size() < exp3_q.size()); c++)
            @(negedge clk);
    endtask

    task automatic test_reset();
        rst2 = 1'b1; rst3 = 1'b1; in_valid = 1'b0; ordy2 = 1'b1; ordy3 = 1'b1;
        lane_en = '1; sig1 = '0; sig2 = '0; expo = '0;
        #1; rst2 = 1'b0; rst3 = 1'b0;
        #2;
        total++; if (ovld2 !== 1'b0) begin bad++; $display("FAIL reset_ovld2 got %b want 0", ovld2); end
        total++; if (ovld3 !== 1'b0) begin bad++; $display("FAIL reset_ovld3 got %b want 0", ovld3); end
        total++; if ({osig2, osign2, ozero2, olzc2, oexp2} !== '0) begin
            bad++; $display("FAIL reset_data2 got %h want 0", {osig2, osign2, ozero2, olzc2, oexp2}); end
        total++; if ({osig3, osign3, ozero3, olzc3, oexp3} !== '0) begin
            bad++; $display("FAIL reset_data3 got %h want 0", {osig3, osign3, ozero3, olzc3, oexp3}); end
        repeat (2) @(posedge clk);
        #1; rst2 = 1'b1; rst3 = 1'b1;
        @(negedge clk);
        total++; if (irdy2 !== 1'b1) begin bad++; $display("FAIL reset_irdy2 got %b want 1", irdy2); end
        total++; if (irdy3 !== 1'b1) begin bad++; $display("FAIL reset_irdy3 got %b want 1", irdy3); end
    endtask

    task automatic test_directed();
        beat_t ea, eb;
        ea.sig  = {26'd0, 26'h2000000, 26'd0, 26'd2};
        ea.sign = 4'b0100;
        ea.zero = 4'b1010;
        ea.lzc  = {5'd26, 5'd0, 5'd26, 5'd24};
        ea.ex   = {8'h00, 8'h33, 8'h22, 8'h11};
        eb = ea;
        eb.sign = 4'b0101;
        @(posedge clk); #1;
        in_valid = 1'b1; lane_en = 4'b0111;
        sig1 = {26'h1234, 26'h2000000, 26'd7, 26'd5};
        sig2 = {26'h3, 26'd0, 26'h3FFFFF9, 26'h3FFFFFD};
        expo = {8'h44, 8'h33, 8'h22, 8'h11};
        @(posedge clk); #1;
        sig1[25:0] = 26'd3;
        sig2[25:0] = 26'h3FFFFFB;
        drain();
        total++; if (got2_q.size() !== 2) begin bad++; $display("FAIL dir_count2 got %0d want 2", got2_q.size()); end
        total++; if (got3_q.size() !== 2) begin bad++; $display("FAIL dir_count3 got %0d want 2", got3_q.size()); end
        if (got2_q.size() == 2) begin
            total++; if (got2_q[0] !== ea) begin bad++; $display("FAIL dir_a_d2 got %h want %h", got2_q[0], ea); end
            total++; if (got2_q[1] !== eb) begin bad++; $display("FAIL dir_b_d2 got %h want %h", got2_q[1], eb); end
        end
        if (got3_q.size() == 2) begin
            total++; if (got3_q[0] !== ea) begin bad++; $display("FAIL dir_a_d3 got %h want %h", got3_q[0], ea); end
            total++; if (got3_q[1] !== eb) begin bad++; $display("FAIL dir_b_d3 got %h want %h", got3_q[1], eb); end
        end
        clear_queues();
    endtask

    task automatic test_stall_d2();
        int want_rdy[3] = '{1, 1, 0};
        int want_vld[3] = '{0, 0, 1};
        @(posedge clk); #1;
        ordy2 = 1'b0; ordy3 = 1'b1; in_valid = 1'b1; drive_rand();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++; if (irdy2 !== want_rdy[c][0]) begin
                bad++; $display("FAIL stall_irdy cyc %0d got %b want %0d", c, irdy2, want_rdy[c]); end
            total++; if (ovld2 !== want_vld[c][0]) begin
                bad++; $display("FAIL stall_ovld cyc %0d got %b want %0d", c, ovld2, want_vld[c]); end
            @(posedge clk); #1;
            drive_rand();
        end
        total++; if (exp2_q.size() !== 2) begin bad++; $display("FAIL stall_buffered got %0d want 2", exp2_q.size()); end
        ordy2 = 1'b1;
        repeat (6) begin @(posedge clk); #1; drive_rand(); end
        drain();
        total++; if (got2_q.size() !== exp2_q.size()) begin
            bad++; $display("FAIL stall_count2 got %0d want %0d", got2_q.size(), exp2_q.size()); end
        for (int j = 0; j < got2_q.size() && j < exp2_q.size(); j++) begin
            total++; if (got2_q[j] !== exp2_q[j]) begin
                bad++; $display("FAIL stall_beat2 %0d got %h want %h", j, got2_q[j], exp2_q[j]); end
        end
        total++; if (got3_q.size() !== exp3_q.size()) begin
            bad++; $display("FAIL stall_count3 got %0d want %0d", got3_q.size(), exp3_q.size()); end
        for (int j = 0; j < got3_q.size() && j < exp3_q.size(); j++) begin
            total++; if (got3_q[j] !== exp3_q[j]) begin
                bad++; $display("FAIL stall_beat3 %0d got %h want %h", j, got3_q[j], exp3_q[j]); end
        end
        clear_queues();
    endtask

    task automatic test_random_stream();
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            in_valid = ($urandom_range(0, 3) != 0);
            ordy2 = ($urandom_range(0, 9) < 7);
            ordy3 = ($urandom_range(0, 9) < 6);
            drive_rand();
        end
        drain();
        total++; if (exp2_q.size() < 100) begin bad++; $display("FAIL rand_accepts2 got %0d want >=100", exp2_q.size()); end
        total++; if (got2_q.size() !== exp2_q.size()) begin
            bad++; $display("FAIL rand_count2 got %0d want %0d", got2_q.size(), exp2_q.size()); end
        for (int j = 0; j < got2_q.size() && j < exp2_q.size(); j++) begin
            total++; if (got2_q[j] !== exp2_q[j]) begin
                bad++; $display("FAIL rand_beat2 %0d got %h want %h", j, got2_q[j], exp2_q[j]); end
        end
        total++; if (got3_q.size() !== exp3_q.size()) begin
            bad++; $display("FAIL rand_count3 got %0d want %0d", got3_q.size(), exp3_q.size()); end
        for (int j = 0; j < got3_q.size() && j < exp3_q.size(); j++) begin
            total++; if (got3_q[j] !== exp3_q[j]) begin
                bad++; $display("FAIL rand_beat3 %0d got %h want %h", j, got3_q[j], exp3_q[j]); end
        end
        total++; if (hold_err2 !== 0) begin bad++; $display("FAIL hold_stable2 got %0d want 0", hold_err2); end
        total++; if (hold_err3 !== 0) begin bad++; $display("FAIL hold_stable3 got %0d want 0", hold_err3); end
        clear_queues();
    endtask

    task automatic test_reset_midflight();
        int stale, lat;
        @(posedge clk); #1;
        ordy2 = 1'b1; ordy3 = 1'b1; in_valid = 1'b1; drive_rand();
        repeat (2) begin @(posedge clk); #1; drive_rand(); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if (ovld3 !== 1'b1) begin bad++; $display("FAIL mid_inflight got %b want 1", ovld3); end
        #2; rst3 = 1'b0;
        #1;
        total++; if (ovld3 !== 1'b0) begin bad++; $display("FAIL mid_ovld_async got %b want 0", ovld3); end
        total++; if ({osig3, osign3, ozero3, olzc3, oexp3} !== '0) begin
            bad++; $display("FAIL mid_data_async got %h want 0", {osig3, osign3, ozero3, olzc3, oexp3}); end
        exp3_q.delete(); got3_q.delete();
        @(posedge clk); #1; rst3 = 1'b1;
        @(negedge clk);
        total++; if (irdy3 !== 1'b1) begin bad++; $display("FAIL mid_irdy got %b want 1", irdy3); end
        stale = 0;
        for (int c = 0; c < 5; c++) begin
            if (ovld3 !== 1'b0) stale++;
            @(negedge clk);
        end
        total++; if (stale !== 0) begin bad++; $display("FAIL mid_stale got %0d want 0", stale); end
        @(posedge clk); #1;
        in_valid = 1'b1; drive_rand();
        @(negedge clk);
        total++; if (irdy3 !== 1'b1) begin bad++; $display("FAIL mid_accept got %b want 1", irdy3); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            lat++;
            if (ovld3 === 1'b1) break;
        end
        total++; if (lat !== 3) begin bad++; $display("FAIL mid_latency got %0d want 3", lat); end
        drain();
        total++; if (got3_q.size() !== 1 || exp3_q.size() !== 1) begin
            bad++; $display("FAIL mid_count3 got %0d/%0d want 1/1", got3_q.size(), exp3_q.size()); end
        else begin
            total++; if (got3_q[0] !== exp3_q[0]) begin
                bad++; $display("FAIL mid_beat3 got %h want %h", got3_q[0], exp3_q[0]); end
        end
        total++; if (got2_q.size() !== exp2_q.size()) begin
            bad++; $display("FAIL mid_count2 got %0d want %0d", got2_q.size(), exp2_q.size()); end
        for (int j = 0; j < got2_q.size() && j < exp2_q.size(); j++) begin
            total++; if (got2_q[j] !== exp2_q[j]) begin
                bad++; $display("FAIL mid_beat2 %0d got %h want %h", j, got2_q[j], exp2_q[j]); end
        end
        clear_queues();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_stall_d2();
        test_random_stream();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_sig_add_pipe.md
FP_SIG_ADD_PIPE -- requirements
Module: fp_sig_add_pipe

Interface
REQ-001 Parameter SIG_WIDTH, default 23, significand width; internal sum width W = SIG_WIDTH+3.
REQ-002 Parameter EXP_WIDTH, default 8, exponent width.
REQ-003 Parameter LANES, default 16, independent vector lanes.
REQ-004 Parameter PIPE_DEPTH, default 1, legal range 1..3, number of register stages.
REQ-005 clk  in  1  single clock; all flops rise-edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 in_valid  in  1  input beat present.
REQ-008 in_ready  out  1  block accepts a beat this cycle.
REQ-009 in_lane_en  in  LANES  per-lane enable mask.
REQ-010 in_sig1, in_sig2  in  LANES*W  two's-complement aligned significands, lane i at bits [i*W +: W].
REQ-011 in_exponent  in  LANES*EXP_WIDTH  per-lane exponent, passed through.
REQ-012 out_valid  out  1  result beat present.
REQ-013 out_ready  in  1  downstream accepts the beat.
REQ-014 out_sig  out  LANES*W  unsigned magnitude per lane.
REQ-015 out_sign  out  LANES  per-lane sign, 1 = negative.
REQ-016 out_zero  out  LANES  per-lane magnitude-is-zero flag.
REQ-017 out_lzc  out  LANES*L  per-lane leading-zero count of out_sig, L = clog2(W+1).
REQ-018 out_exponent  out  LANES*EXP_WIDTH  exponent aligned with its result.

Function
REQ-019 Per lane: sum = (in_sig1 + in_sig2) mod 2^W; carry out discarded.
REQ-020 sum[W-1]=1 -> magnitude = (~sum+1) mod 2^W, sign=1; else magnitude=sum, sign=0.
REQ-021 sum = 2^(W-1) (most negative) -> magnitude 2^(W-1), sign 1, lzc 0; no saturation.
REQ-022 magnitude 0 -> zero=1, sign=0, lzc=W.
REQ-023 lzc = number of leading zero bits of the W-bit magnitude.
REQ-024 in_lane_en[i]=0 -> lane i outputs magnitude 0, sign 0, zero 1, lzc W, exponent 0.
REQ-025 All arithmetic is combinational ahead of stage 1; stages 2..PIPE_DEPTH are pure delay (retiming).
REQ-026 Beat accepted when in_valid && in_ready; beat delivered when out_valid && out_ready.
REQ-027 Stage k advances when empty or when stage k+1 advances/is empty; last stage advances on out_ready.
REQ-028 in_ready = stage 1 empty or stage 1 advancing this cycle (combinational, no extra bubble).
REQ-029 Latency with no stall: exactly PIPE_DEPTH cycles from acceptance to out_valid.
REQ-030 Throughput: one beat per cycle while out_ready=1; up to PIPE_DEPTH beats buffered under stall.
REQ-031 Stalled stage holds data and valid unchanged; no beat dropped, duplicated or reordered.
REQ-032 out_* data is held stable while out_valid=1 and out_ready=0.
REQ-033 Simultaneous accept and deliver on a full pipe are legal and lossless.

Reset
REQ-034 reset_n low -> all stage valids 0 and all data flops 0 immediately; out_valid=0, out_sig=0, out_sign=0, out_zero=0, out_lzc=0, out_exponent=0.
REQ-035 Reset mid-operation discards all in-flight beats; in_ready=1 from the first cycle after reset_n rises.

Structure
REQ-036 W, L and lane slice helpers reside in shared package fp_pkg alongside existing FP width constants.
REQ-037 One combinational sub-module fp_sig_add_lane (add, negate, zero, lzc) instantiated LANES times.
REQ-038 Pipeline valid/hold control is implemented once, shared by all lanes.

Verification
REQ-039 SIG_WIDTH=23, lane0 5 + 0x3FFFFFD (-3) -> out_sig 2, sign 0, zero 0, lzc 24.
REQ-040 Lane0 3 + 0x3FFFFFB (-5) -> out_sig 2, sign 1, lzc 24; lane1 7 + 0x3FFFFF9 -> out_sig 0, zero 1, sign 0, lzc 26.
REQ-041 Lane0 0x2000000 + 0 -> out_sig 0x2000000, sign 1, lzc 0; in_lane_en=0 lane -> zero 1, lzc 26.
REQ-042 PIPE_DEPTH=2, continuous in_valid, out_ready low 3 cycles -> in_ready drops after 2 buffered beats, all beats emerge in order, none lost.
REQ-043 PIPE_DEPTH=3, reset_n pulsed low with 3 beats in flight -> out_valid 0 immediately, no stale beat after release, next beat has latency 3.
